// File: rtl/wm8731_cfg_seq.sv
// WM8731 power-up register sequencer with a bit-banged two-wire (I2C) write master.
// Optional volume-update port set is enabled by defining WM8731_CFG_SEQ_VOL_EN.
module wm8731_cfg_seq #(
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned AUTO_START = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_idx,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
`ifdef WM8731_CFG_SEQ_VOL_EN
  ,
  input  logic       vol_req,
  input  logic [6:0] vol_dat,
  output logic       vol_ack
`endif
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [3:0]  LAST_IDX = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, div_clr;
  logic [1:0]       q, q_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [1:0]       byte_idx, byte_nx;
  logic [3:0]       index, index_nx;
  logic [RTY_W-1:0] retry, retry_nx;
  logic             nack, nack_nx;
  logic             busy_nx, done_nx, err_nx;
  logic [3:0]       err_idx_nx;
  logic             auto_pend;
  logic             scl_nx, sda_nx;
  logic [15:0]      entry;
  logic [7:0]       cur_byte;
  logic             vol_mode;
  logic [6:0]       vol_lat;
  logic             last_entry;

`ifdef WM8731_CFG_SEQ_VOL_EN
  logic             vol_mode_nx, vol_ack_nx;
  logic [6:0]       vol_lat_nx;
`else
  assign vol_mode = 1'b0;
  assign vol_lat  = '0;
`endif

  // Each entry is {reg[6:0], data[8:0]}.
  function automatic logic [15:0] tbl_entry(input logic [3:0] i);
    case (i)
      4'd0:    tbl_entry = {7'd15, 9'h000};
      4'd1:    tbl_entry = {7'd0,  9'h017};
      4'd2:    tbl_entry = {7'd1,  9'h017};
      4'd3:    tbl_entry = {7'd2,  9'h079};
      4'd4:    tbl_entry = {7'd3,  9'h079};
      4'd5:    tbl_entry = {7'd4,  9'h012};
      4'd6:    tbl_entry = {7'd5,  9'h000};
      4'd7:    tbl_entry = {7'd6,  9'h000};
      4'd8:    tbl_entry = {7'd7,  9'h002};
      4'd9:    tbl_entry = {7'd8,  9'h000};
      4'd10:   tbl_entry = {7'd9,  9'h001};
      default: tbl_entry = '0;
    endcase
  endfunction

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_comb begin
    entry = tbl_entry(index);
    if (vol_mode) entry[8:0] = {2'b01, vol_lat};
    case (byte_idx)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = entry[15:8];
      default: cur_byte = entry[7:0];
    endcase
    last_entry = vol_mode ? (index == 4'd4) : (index == LAST_IDX);
  end

  // Bus levels per quarter; registered below so pins never glitch on decode.
  always_comb begin
    scl_nx = 1'b1;
    sda_nx = 1'b0;
    case (state)
      S_START: begin
        scl_nx = (q != 2'd3);
        sda_nx = (q != 2'd0);
      end
      S_BYTE: begin
        scl_nx = (q == 2'd1) || (q == 2'd2);
        sda_nx = ~cur_byte[bit_idx];
      end
      S_ACK: begin
        scl_nx = (q == 2'd1) || (q == 2'd2);
        sda_nx = 1'b0;
      end
      S_STOP: begin
        scl_nx = (q != 2'd0);
        sda_nx = (q < 2'd2);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    q_nx       = q;
    bit_nx     = bit_idx;
    byte_nx    = byte_idx;
    index_nx   = index;
    retry_nx   = retry;
    nack_nx    = nack;
    busy_nx    = busy;
    done_nx    = done;
    err_nx     = err;
    err_idx_nx = err_idx;
    div_clr    = 1'b0;
`ifdef WM8731_CFG_SEQ_VOL_EN
    vol_mode_nx = vol_mode;
    vol_lat_nx  = vol_lat;
    vol_ack_nx  = 1'b0;
`endif
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start || auto_pend) begin
          state_nx = S_START;
          q_nx     = 2'd0;
          index_nx = '0;
          retry_nx = '0;
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          busy_nx  = 1'b1;
          div_clr  = 1'b1;
`ifdef WM8731_CFG_SEQ_VOL_EN
          vol_mode_nx = 1'b0;
        end else if ((state == S_DONE) && vol_req) begin
          // Volume update reuses table slots 3/4 (R2/R3) with substituted data.
          state_nx    = S_START;
          q_nx        = 2'd0;
          index_nx    = 4'd3;
          retry_nx    = '0;
          busy_nx     = 1'b1;
          div_clr     = 1'b1;
          vol_mode_nx = 1'b1;
          vol_lat_nx  = vol_dat;
`endif
        end
      end
      S_START: if (tick) begin
        q_nx = q + 2'd1;
        if (q == 2'd3) begin
          state_nx = S_BYTE;
          byte_nx  = 2'd0;
          bit_nx   = 3'd7;
          nack_nx  = 1'b0;
        end
      end
      S_BYTE: if (tick) begin
        q_nx = q + 2'd1;
        if (q == 2'd3) begin
          if (bit_idx == 3'd0) state_nx = S_ACK;
          else                 bit_nx   = bit_idx - 3'd1;
        end
      end
      S_ACK: if (tick) begin
        q_nx = q + 2'd1;
        if (q == 2'd2) nack_nx = sda_i;
        if (q == 2'd3) begin
          if (nack || (byte_idx == 2'd2)) begin
            state_nx = S_STOP;
          end else begin
            state_nx = S_BYTE;
            byte_nx  = byte_idx + 2'd1;
            bit_nx   = 3'd7;
          end
        end
      end
      S_STOP: if (tick) begin
        q_nx = q + 2'd1;
        if (q == 2'd3) begin
          state_nx = S_GAP;
`ifdef WM8731_CFG_SEQ_VOL_EN
          if (vol_mode && !nack && (index == 4'd4)) vol_ack_nx = 1'b1;
`endif
        end
      end
      S_GAP: if (tick) begin
        q_nx = q + 2'd1;
        if (q == 2'd3) begin
          if (!nack) begin
            state_nx = S_NEXT;
          end else if (retry == RTY_W'(MAX_RETRY)) begin
            state_nx   = S_ERR;
            err_nx     = 1'b1;
            err_idx_nx = index;
            busy_nx    = 1'b0;
`ifdef WM8731_CFG_SEQ_VOL_EN
            vol_mode_nx = 1'b0;
`endif
          end else begin
            state_nx = S_START;
            retry_nx = retry + RTY_W'(1);
          end
        end
      end
      // Single-clk bookkeeping; the divider keeps running so the tick grid is unchanged.
      S_NEXT: begin
        index_nx = index + 4'd1;
        retry_nx = '0;
        q_nx     = 2'd0;
        if (last_entry) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
`ifdef WM8731_CFG_SEQ_VOL_EN
          vol_mode_nx = 1'b0;
`endif
        end else begin
          state_nx = S_START;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      q         <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      index     <= '0;
      retry     <= '0;
      nack      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      scl_o     <= 1'b1;
      sda_oe    <= 1'b0;
      auto_pend <= (AUTO_START != 0);
    end else begin
      state     <= state_nx;
      div_cnt   <= (div_clr || tick) ? '0 : div_cnt + DIV_W'(1);
      q         <= q_nx;
      bit_idx   <= bit_nx;
      byte_idx  <= byte_nx;
      index     <= index_nx;
      retry     <= retry_nx;
      nack      <= nack_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      err_idx   <= err_idx_nx;
      scl_o     <= scl_nx;
      sda_oe    <= sda_nx;
      auto_pend <= 1'b0;
    end
  end

`ifdef WM8731_CFG_SEQ_VOL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_mode <= 1'b0;
      vol_lat  <= '0;
      vol_ack  <= 1'b0;
    end else begin
      vol_mode <= vol_mode_nx;
      vol_lat  <= vol_lat_nx;
      vol_ack  <= vol_ack_nx;
    end
  end
`endif

endmodule

// File: doc/wm8731_cfg_seq.md
Name: wm8731_cfg_seq

Overview:
- Power-up configuration sequencer for the WM8731 codec, which feeds the I2S interface block.
- Walks a fixed 11-entry register table and issues one I2C write per entry. Built-in bit-banged two-wire master.
- Asserts done once the codec is in I2S slave, 16-bit, active mode, so the audio datapath can be released.
- Retries NACKed writes; flags a persistent error.

Parameters:
- CLK_DIV, 125: clk cycles per quarter SCL period (tick); SCL period = 4*CLK_DIV clk.
- DEV_ADDR, 7'h1A: codec 7-bit I2C address; write byte = {DEV_ADDR,1'b0} = 8'h34.
- MAX_RETRY, 3: extra attempts per entry after a NACK.
- AUTO_START, 1: 1 = run the sequence automatically once after reset deassertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; (re)runs the full table
- busy  out  1  sequence in progress
- done  out  1  table written successfully; held until next accepted start
- err  out  1  entry failed after 1+MAX_RETRY attempts; held until next accepted start
- err_idx  out  4  table index of the failing entry
- scl_o  out  1  SCL, push-pull
- sda_oe  out  1  1 = drive SDA low; 0 = release (pulled up)
- sda_i  in  1  SDA pin sample

Behaviour:
- Reset is asynchronous on rst_n, active-low, clock clk. Reset values: scl_o=1, sda_oe=0, busy=0, done=0, err=0, err_idx=0; FSM=IDLE, index=0, retry count=0, tick divider=0.
- Register table, index 0..10, as {reg[6:0], data[8:0]}:
  - 0: R15 = 0x000 (codec reset)
  - 1/2: R0/R1 = 0x017
  - 3/4: R2/R3 = 0x079
  - 5: R4 = 0x012
  - 6: R5 = 0x000
  - 7: R6 = 0x000
  - 8: R7 = 0x002 (I2S, 16-bit, slave)
  - 9: R8 = 0x000
  - 10: R9 = 0x001 (active)
- Transaction bytes: 8'h34, {reg[6:0], data[8]}, data[7:0]. Each byte is sent MSB first, followed by one ACK slot.
- Tick: a divider counter pulses every CLK_DIV clk. All FSM progress happens on ticks only.
- Bit slot = 4 ticks:
  - q0: SCL low, SDA updated
  - q1: SCL high
  - q2: SCL high, sda_i sampled
  - q3: SCL low
- States:
  - IDLE
  - START: SDA falls while SCL high, 4 ticks
  - BYTE: 8 slots
  - ACK: 1 slot, SDA released, sample sda_i
  - STOP: SDA rises while SCL high, 4 ticks
  - GAP: 4 ticks, bus idle
  - NEXT
  - DONE
  - ERR
- Transaction length = 4 + 27*4 + 4 + 4 = 120 ticks. The full table takes 1320 ticks on the no-retry path.
- ACK handling:
  - sda_i=0 at q2 of an ACK slot means ACK: continue.
  - sda_i=1 means NACK: abort to STOP, then GAP, then restart the same entry from START and increment the retry count.
  - When the retry count exceeds MAX_RETRY: go to ERR, set err=1 and err_idx=index, clear busy.
- NEXT: index++. Retry count clears. index==11 → DONE: done=1, busy=0.
- Start acceptance:
  - start is accepted only in IDLE, DONE or ERR. It clears done, err and index, sets busy the next clk, and starts the divider fresh.
  - start while busy is ignored.
- AUTO_START=1: an internal one-shot behaves as a start on the first clk after reset release.
- Reset mid-transaction: bus released immediately (async). No recovery clocking is issued; the next run begins with a fresh START.

Optional Feature:
- Macro: WM8731_CFG_SEQ_VOL_EN.
- When defined, adds ports:
  - vol_req  in  1
  - vol_dat  in  7
  - vol_ack  out  1, reset 0
- In DONE, a vol_req high is accepted. The block then writes R2 and R3 with {2'b01, vol_dat}, with vol_dat latched at acceptance. Retry and err rules are the same as for the table.
- vol_ack pulses for 1 clk after the second write's STOP. busy is high during the update.
- vol_req outside DONE is ignored.
- When undefined: the ports are absent and DONE is terminal until start.

Test Plan:
- Reset: outputs at reset values. AUTO_START=0 → scl_o=1, sda_oe=0 held for 10000 clk.
- CLK_DIV=4, ACKing slave model, start pulse → 11 transactions decoded, the first 34/1E/00 and the last 34/12/01. done=1 at ≤1320*4+8 clk after start. busy falls the same cycle done rises.
- Slave NACKs the address byte of entry 3 once → STOP, GAP, then entry 3 is resent. The table completes with done=1 and err=0.
- Slave NACKs entry 5 always, MAX_RETRY=3 → exactly 4 attempts of entry 5, then err=1, err_idx=5, done=0, bus idle.
- start pulsed mid-sequence is ignored (index unaffected). rst_n low mid-byte → scl_o=1 and sda_oe=0 with no clk edge needed. A new start re-sends from entry 0.
- WM8731_CFG_SEQ_VOL_EN, after done: vol_req with vol_dat=7'h60 → writes 34/04/E0 and 34/06/E0, then one vol_ack pulse.
